// File: rtl/instr_encode.sv
// Instruction-field encoder: packs R/I/D/B field bundles into machine words
// and streams them as sequential writes into instruction memory.
module instr_encode #(
    parameter int INSTR_LEN = 32,
    parameter int MEM_WORDS = 64,
    parameter int BASE_ADDR = 0,
    localparam int CW = $clog2(MEM_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rm_num,
    input  logic [4:0]           rn_num,
    input  logic [4:0]           rd_num,
    input  logic [5:0]           shamt,
    input  logic [8:0]           address,
    input  logic [25:0]          imm,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [INSTR_LEN-1:0] wr_data,
    output logic [CW-1:0]        count,
    output logic                 full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_D = 2'd2;
    localparam logic [1:0] FMT_B = 2'd3;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic [INSTR_LEN-1:0]   r_data;
    logic [31:0]            w_enc;
    logic                   w_accept;
    logic                   w_last;

    always_comb begin
        w_enc = '0;
        unique case (fmt)
            FMT_R: w_enc = {opcode, rm_num, shamt, rn_num, rd_num};
            FMT_I: w_enc = {opcode[10:1], imm[11:0], rn_num, rd_num};
            FMT_D: w_enc = {opcode, address, 2'b00, rn_num, rd_num};
            FMT_B: w_enc = {opcode[10:5], imm};
            default: w_enc = '0;
        endcase
    end

    assign in_ready = (r_state == IDLE) && !clear && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_count == CW'(MEM_WORDS - 1));

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = WRITE;
            end
            WRITE: begin
                w_count_next = r_count + 1'b1;
                w_state_next = w_last ? FULL : IDLE;
            end
            FULL: w_state_next = FULL;
            default: w_state_next = IDLE;
        endcase
        // clear abandons any pending write and restarts the address sequence
        if (clear) begin
            w_state_next = IDLE;
            w_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) r_data <= INSTR_LEN'(w_enc);
        end
    end

    assign wr_en   = (r_state == WRITE) && !clear && !rst;
    assign wr_addr = 32'(BASE_ADDR) + (32'(r_count) << 2);
    assign wr_data = r_data;
    assign count   = r_count;
    assign full    = (r_count == CW'(MEM_WORDS));

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: hand-encoded ARM-style words, fill to
// full, clear restart, and reset/clear priority cases.
module tb_instr_encode;

    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [10:0]   opcode;
    logic [4:0]    rm_num;
    logic [4:0]    rn_num;
    logic [4:0]    rd_num;
    logic [5:0]    shamt;
    logic [8:0]    address;
    logic [25:0]   imm;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [CW-1:0] count;
    logic          full;

    int n_chk = 0;
    int n_err = 0;

    instr_encode #(
        .INSTR_LEN(32),
        .MEM_WORDS(MW),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode),
        .rm_num(rm_num), .rn_num(rn_num), .rd_num(rd_num),
        .shamt(shamt), .address(address), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [10:0] op,
                              input logic [4:0] rm, input logic [5:0] sh,
                              input logic [4:0] rn, input logic [4:0] rd,
                              input logic [8:0] ad, input logic [25:0] im);
        fmt = f; opcode = op; rm_num = rm; shamt = sh;
        rn_num = rn; rd_num = rd; address = ad; imm = im;
    endtask

    // Present one bundle for one edge, then check the single write strobe.
    task automatic send(input string tag, input logic [31:0] exp_data,
                        input logic [31:0] exp_addr,
                        input logic [CW-1:0] exp_cnt);
        @(negedge clk);
        in_valid = 1'b1;
        #1 check({tag, ".ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, ".wr_en"}, 32'(wr_en), 32'd1);
        check({tag, ".data"}, wr_data, exp_data);
        check({tag, ".addr"}, wr_addr, exp_addr);
        @(negedge clk);
        #1;
        check({tag, ".wr_en_off"}, 32'(wr_en), 32'd0);
        check({tag, ".count"}, 32'(count), 32'(exp_cnt));
        check({tag, ".hold"}, wr_data, exp_data);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        set_fields(2'd0, 11'd0, 5'd0, 6'd0, 5'd0, 5'd0, 9'd0, 26'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.full", 32'(full), 32'd0);
        check("rst.wr_en", 32'(wr_en), 32'd0);
        check("rst.data", wr_data, 32'd0);
        check("rst.addr", wr_addr, 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);

        set_fields(2'd2, 11'd1986, 5'd31, 6'd63, 5'd22, 5'd9, 9'd240, 26'h3FFFFFF);
        send("ldur", 32'hF84F02C9, 32'd0, 2'd1);
        set_fields(2'd0, 11'd1112, 5'd9, 6'd0, 5'd21, 5'd10, 9'h1FF, 26'h3FFFFFF);
        send("add", 32'h8B0902AA, 32'd4, 3'd2);
        set_fields(2'd2, 11'd1984, 5'd0, 6'd0, 5'd23, 5'd10, 9'd64, 26'd0);
        send("stur", 32'hF80402EA, 32'd8, 3'd3);
        set_fields(2'd1, 11'h488, 5'd31, 6'd5, 5'd22, 5'd9, 9'd3, 26'h3FFF001);
        send("addi", 32'h910006C9, 32'd12, 3'd4);

        check("full.flag", 32'(full), 32'd1);
        check("full.ready", 32'(in_ready), 32'd0);
        set_fields(2'd3, 11'h0A0, 5'd1, 6'd1, 5'd1, 5'd1, 9'd1, 26'd10);
        @(negedge clk);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 check("full.no_wr", 32'(wr_en), 32'd0);
        end
        in_valid = 1'b0;
        check("full.count", 32'(count), 32'd4);
        check("full.data", wr_data, 32'h910006C9);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr.count", 32'(count), 32'd0);
        check("clr.full", 32'(full), 32'd0);
        check("clr.addr", wr_addr, 32'd0);
        send("b", 32'h1400000A, 32'd0, 3'd1);

        // reset asserted during the write cycle discards the write
        set_fields(2'd0, 11'd1112, 5'd9, 6'd0, 5'd21, 5'd10, 9'd0, 26'd0);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("rstw.wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw.count", 32'(count), 32'd0);
        check("rstw.data", wr_data, 32'd0);
        check("rstw.ready", 32'(in_ready), 32'd1);

        // clear together with in_valid: bundle must not be taken
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        #1 check("clrv.ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clrv.wr_en", 32'(wr_en), 32'd0);
        check("clrv.data", wr_data, 32'd0);
        @(negedge clk);
        #1 check("clrv.count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
